// File: rtl/demux_param_nb_if.sv
// rtl/demux_param_nb_if.sv - word-in / slice-out handshake bundle for demux_param_nb (out_par only with DEMUX_PARITY_EN)
interface demux_param_nb_if #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 8
);
    logic [IN_W-1:0]  in_data;
    logic             in_valid;
    logic             in_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic             busy;
`ifdef DEMUX_PARITY_EN
    logic             out_par;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last, busy, out_par
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last, busy, out_par
    );
`else
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last, busy
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last, busy
    );
`endif
endinterface

// File: rtl/demux_param_nb.sv
// rtl/demux_param_nb.sv - wide-to-narrow serializer with 2-word input buffer; DEMUX_PARITY_EN adds registered slice parity out_par
module demux_param_nb #(
    parameter int IN_W      = 32,
    parameter int OUT_W     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic           clk_4f,
    input  logic           reset,
    demux_param_nb_if.slave bus
);
    localparam int RATIO = IN_W / OUT_W;
    localparam int IDX_W = $clog2(RATIO);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    generate
        if ((IN_W % OUT_W) != 0 || RATIO < 2) begin : g_bad_params
            $error("demux_param_nb: IN_W must be a multiple of OUT_W with ratio >= 2");
        end
    endgenerate

    logic [IN_W-1:0]  fifo_mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic [IDX_W-1:0] idx;

    logic [OUT_W-1:0] out_data_q;
    logic             out_valid_q;
    logic             out_last_q;

    logic             push;
    logic             load;
    logic             last_slice;
    logic             pop;
    logic [IDX_W-1:0] sel;
    logic [IN_W-1:0]  head_shifted;
    logic [OUT_W-1:0] slice;

    assign bus.in_ready = (count != 2'd2) && !reset;
    assign push         = bus.in_valid && bus.in_ready;
    assign load         = (!out_valid_q || bus.out_ready) && (count != 2'd0);
    assign last_slice   = (idx == LAST_IDX);
    assign pop          = load && last_slice;

    // Slice 0 sits at the top of the word when MSB_FIRST, otherwise at the bottom.
    assign sel          = MSB_FIRST ? (LAST_IDX - idx) : idx;
    assign head_shifted = fifo_mem[rd_ptr] >> (int'(sel) * OUT_W);
    assign slice        = head_shifted[OUT_W-1:0];

    always_ff @(posedge clk_4f) begin
        if (push) begin
            fifo_mem[wr_ptr] <= bus.in_data;
        end
    end

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            idx <= '0;
        end else if (load) begin
            idx <= last_slice ? '0 : idx + 1'b1;
        end
    end

    // The output register holds its value under backpressure because load is false then.
    always_ff @(posedge clk_4f) begin
        if (reset) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else if (load) begin
            out_data_q  <= slice;
            out_valid_q <= 1'b1;
            out_last_q  <= last_slice;
        end else if (out_valid_q && bus.out_ready) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end
    end

`ifdef DEMUX_PARITY_EN
    logic out_par_q;

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            out_par_q <= 1'b0;
        end else if (load) begin
            out_par_q <= ^slice;
        end else if (out_valid_q && bus.out_ready) begin
            out_par_q <= 1'b0;
        end
    end

    assign bus.out_par = out_par_q;
`endif

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.busy      = (count != 2'd0) || out_valid_q;
endmodule
